// File: rtl/pmod_cmd.sv
// pmod_cmd: byte-stream command parser driving word-oriented write/read bus requests.
// Define PMOD_CMD_ACK_EN to have every WRITE answered with an 0xA5 byte.
module pmod_cmd (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        write_req,
  output logic        write_bus_req,
  output logic        read_req,
  output logic        read_bus_req,
  input  logic        busy,
  output logic [9:0]  len,
  output logic [31:0] address,
  output logic [63:0] wdata,
  input  logic [63:0] rdata
);
  typedef enum logic [3:0] {IDLE, HDR, WCOL, WPUSH, WISSUE, RISSUE, RREQ, RWAIT, RSEND, ACK} state_t;
  state_t      r_state;
  logic        r_run;
  logic        r_read;
  logic [2:0]  r_hcnt;
  logic [2:0]  r_k;
  logic [6:0]  r_wc;
  logic [63:0] r_rbuf;
  logic        w_rx;
  logic        w_tx;
  logic        w_sub;
  logic [3:0]  w_nb;
  logic [6:0]  w_nw;
  logic [2:0]  w_lane;
  logic [2:0]  w_lane_n;
  logic        w_last_b;
  logic        w_last_w;
  assign rx_ready      = r_run & (r_state == IDLE | r_state == HDR | r_state == WCOL);
  assign w_rx          = rx_valid & rx_ready;
  assign w_tx          = tx_valid & tx_ready;
  // Requests are gated by busy in the same cycle so a stalled pulse simply waits in its state.
  assign write_req     = (r_state == WPUSH) & ~busy;
  assign write_bus_req = (r_state == WISSUE) & ~busy;
  assign read_bus_req  = (r_state == RISSUE) & ~busy;
  assign read_req      = (r_state == RREQ) & ~busy;
  assign w_sub         = len[2:0] == 3'd1 | len[2:0] == 3'd2 | len[2:0] == 3'd4;
  assign w_nb          = w_sub ? {1'b0, len[2:0]} : 4'd8;
  assign w_nw          = len[2:0] == 3'd0 ? len[9:3] : 7'd1;
  assign w_lane        = (w_sub ? address[2:0] : 3'd0) + r_k;
  assign w_lane_n      = w_lane + 3'd1;
  assign w_last_b      = {1'b0, r_k} == w_nb - 4'd1;
  assign w_last_w      = r_wc == w_nw - 7'd1;
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state  <= IDLE;
      r_run    <= 1'b0;
      r_read   <= 1'b0;
      r_hcnt   <= 3'd0;
      r_k      <= 3'd0;
      r_wc     <= 7'd0;
      r_rbuf   <= 64'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
      len      <= 10'd0;
      address  <= 32'd0;
      wdata    <= 64'd0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        IDLE: if (w_rx && (rx_data == 8'h01 || rx_data == 8'h02)) begin
          r_read  <= rx_data[1];
          r_hcnt  <= 3'd0;
          r_state <= HDR;
        end
        HDR: if (w_rx) begin
          r_hcnt <= r_hcnt + 3'd1;
          case (r_hcnt)
            3'd0:    len[7:0]       <= rx_data;
            3'd1:    len[9:8]       <= rx_data[1:0];
            3'd2:    address[7:0]   <= rx_data;
            3'd3:    address[15:8]  <= rx_data;
            3'd4:    address[23:16] <= rx_data;
            default: address[31:24] <= rx_data;
          endcase
          if (r_hcnt == 3'd5) begin
            r_k     <= 3'd0;
            r_wc    <= 7'd0;
            wdata   <= 64'd0;
            r_state <= len == 10'd0 ? IDLE : r_read ? RISSUE : WCOL;
          end
        end
        WCOL: if (w_rx) begin
          wdata[{w_lane, 3'b000} +: 8] <= rx_data;
          r_k <= w_last_b ? 3'd0 : r_k + 3'd1;
          if (w_last_b) r_state <= w_sub ? WISSUE : WPUSH;
        end
        WPUSH: if (!busy) begin
          r_wc    <= r_wc + 7'd1;
          r_state <= w_last_w ? WISSUE : WCOL;
        end
        WISSUE: if (!busy) begin
`ifdef PMOD_CMD_ACK_EN
          tx_valid <= 1'b1;
          tx_data  <= 8'hA5;
          r_state  <= ACK;
`else
          r_state  <= IDLE;
`endif
        end
        ACK: if (w_tx) begin
          tx_valid <= 1'b0;
          r_state  <= IDLE;
        end
        RISSUE: if (!busy) r_state <= RREQ;
        RREQ: if (!busy) r_state <= RWAIT;
        RWAIT: begin
          r_rbuf   <= rdata;
          tx_data  <= rdata[{w_lane, 3'b000} +: 8];
          tx_valid <= 1'b1;
          r_state  <= RSEND;
        end
        RSEND: if (w_tx) begin
          if (w_last_b) begin
            tx_valid <= 1'b0;
            r_k      <= 3'd0;
            r_wc     <= r_wc + 7'd1;
            r_state  <= w_last_w ? IDLE : RREQ;
          end else begin
            r_k     <= r_k + 3'd1;
            tx_data <= r_rbuf[{w_lane_n, 3'b000} +: 8];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pmod_cmd.sv
// tb_pmod_cmd: directed scoreboard bench for pmod_cmd; expects 0xA5 acks when PMOD_CMD_ACK_EN is defined.
module tb_pmod_cmd;
  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        write_req, write_bus_req, read_req, read_bus_req, busy;
  logic [9:0]  len;
  logic [31:0] address;
  logic [63:0] wdata, rdata;
  typedef struct {
    logic [3:0]  k;
    logic [41:0] a;
    logic [63:0] d;
  } ev_t;
  ev_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          n_wreq = 0;
  int          n_base;
  logic [41:0] cur_a;
  logic [3:0]  m_k;
  logic [63:0] m_d;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d;
  ev_t         m_e;
  pmod_cmd dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .write_req(write_req), .write_bus_req(write_bus_req),
    .read_req(read_req), .read_bus_req(read_bus_req),
    .busy(busy), .len(len), .address(address), .wdata(wdata), .rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // kinds: 1 write_req, 2 write_bus_req, 3 read_bus_req, 4 read_req, 5 tx byte
  task automatic ev(input logic [3:0] k, input logic [63:0] d);
    q.push_back('{k, cur_a, d});
  endtask
  task automatic ack();
`ifdef PMOD_CMD_ACK_EN
    ev(4'd5, 64'hA5);
`endif
  endtask
  always @(negedge clk) begin
    if (rstn !== 1'b1) prev_stall = 1'b0;
    else begin
      if (prev_stall && tx_valid) chk("tx_hold", tx_data, prev_d);
      m_k = write_req ? 4'd1 : write_bus_req ? 4'd2 : read_bus_req ? 4'd3 : read_req ? 4'd4 :
            (tx_valid && tx_ready) ? 4'd5 : 4'd0;
      m_d = m_k == 4'd5 ? {56'd0, tx_data} : (m_k == 4'd1 || m_k == 4'd2) ? wdata : 64'd0;
      if (m_k != 4'd0 && m_k != 4'd5) begin
        chk("one_pulse", $countones({write_req, write_bus_req, read_req, read_bus_req}), 1);
        chk("busy_quiet", busy, 0);
      end
      if (m_k == 4'd1) n_wreq++;
      if (m_k != 4'd0) begin
        if (q.size() == 0) chk("spurious_event", m_k, 0);
        else begin
          m_e = q.pop_front();
          chk("event", {m_k, len, address, m_d}, {m_e.k, m_e.a, m_e.d});
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_timeout", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask
  task automatic cmd(input logic [7:0] op);
    send_byte(op);
    send_byte(cur_a[39:32]);
    send_byte({6'd0, cur_a[41:40]});
    for (int i = 0; i < 4; i++) send_byte(cur_a[8*i +: 8]);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic peek(input string tag, input logic [127:0] obs_sel, input logic [127:0] exp);
    chk(tag, obs_sel, exp);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1; busy = 1'b0; rdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_pulses", {write_req, write_bus_req, read_req, read_bus_req}, 0);
    chk("rst_len", len, 0);
    chk("rst_address", address, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_tx_data", tx_data, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rx_ready_release", rx_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rx_ready_after", rx_ready, 1);
    @(posedge clk);
    #1;
    // bad opcode is swallowed, the following write must still parse
    send_byte(8'h7F);
    @(negedge clk);
    chk("bad_op_idle", rx_ready, 1);
    @(posedge clk);
    #1;
    cur_a = {10'd1, 32'h80000005};
    ev(4'd2, 64'h0000AA0000000000);
    ack();
    cmd(8'h01);
    send_byte(8'hAA);
    drain();
    // burst write of two words with a busy stall in WPUSH
    cur_a = {10'd16, 32'h00001000};
    ev(4'd1, 64'h0706050403020100);
    ev(4'd1, 64'h0F0E0D0C0B0A0908);
    ev(4'd2, 64'h0F0E0D0C0B0A0908);
    ack();
    n_base = n_wreq;
    cmd(8'h01);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("wpush_rx_ready", rx_ready, 0);
      @(posedge clk);
      #1;
    end
    chk("stall_hold", n_wreq, n_base);
    busy = 1'b0;
    for (int i = 8; i < 16; i++) send_byte(8'(i));
    drain();
    chk("burst_wreq_count", n_wreq, n_base + 2);
    // burst read
    rdata = 64'h1122334455667788;
    cur_a = {10'd8, 32'h00002000};
    ev(4'd3, 64'd0);
    ev(4'd4, 64'd0);
    for (int i = 0; i < 8; i++) ev(4'd5, {56'd0, rdata[8*i +: 8]});
    cmd(8'h02);
    drain();
    // sub-word read from lane 3
    cur_a = {10'd2, 32'h00003003};
    ev(4'd3, 64'd0);
    ev(4'd4, 64'd0);
    ev(4'd5, 64'h55);
    ev(4'd5, 64'h44);
    cmd(8'h02);
    drain();
    // len=0 is a no-op
    cur_a = {10'd0, 32'h00004000};
    cmd(8'h01);
    @(negedge clk);
    chk("len0_idle", rx_ready, 1);
    @(posedge clk);
    #1;
    drain();
    // read under random tx backpressure
    rdata = 64'hA8A7A6A5A4A3A2A1;
    tx_ready = 1'b0;
    cur_a = {10'd8, 32'h00005000};
    ev(4'd3, 64'd0);
    ev(4'd4, 64'd0);
    for (int i = 0; i < 8; i++) ev(4'd5, {56'd0, rdata[8*i +: 8]});
    cmd(8'h02);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_tx_valid", tx_valid, 1);
    chk("bp_tx_data", tx_data, 8'hA1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
    drain();
    // reset in the middle of a burst write discards it
    cur_a = {10'd16, 32'h00006000};
    cmd(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_rx_ready", rx_ready, 0);
    chk("midrst_len_addr", {len, address}, 0);
    chk("midrst_wdata", wdata, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_pulse", n_wreq, n_base + 2);
    // recovery: sub-word write into lanes 6,7
    cur_a = {10'd2, 32'h00000006};
    ev(4'd2, 64'h2211000000000000);
    ack();
    cmd(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
